// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// Parametrised register file with two combinational read ports, one
// synchronous write port and a hardware clear sequencer.
//
// Every entry is loaded with RESET_VAL by the asynchronous reset.  A clear
// request starts a sweep that rewrites RESET_VAL into one entry per clock,
// starting at entry 0 and ending at entry DEPTH-1.  While the sweep runs,
// `busy` is high.  Any write request made while `busy` is high is dropped,
// and `wr_err` pulses for one cycle.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - When defined, write-to-read forwarding is enabled.
//                       A write that will be accepted this cycle appears
//                       combinationally on any read port that addresses the
//                       same entry.
//
// Parameters:
//   DATA_W     width of each register in bits
//   ADDR_W     address width, DEPTH = 2**ADDR_W
//   RESET_VAL  value loaded by reset and by the clear sweep
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   rd_addr_1  in   read port 1 address
//   rd_data_1  out  read port 1 data (combinational)
//   rd_addr_2  in   read port 2 address
//   rd_data_2  out  read port 2 data (combinational)
//   wr_en      in   write request, sampled at the rising edge
//   wr_addr    in   write address
//   wr_data    in   write data
//   clr_req    in   clear-sweep request, sampled at the rising edge
//   busy       out  high while the sweep runs (registered)
//   wr_err     out  one-cycle pulse: a write was dropped during the sweep
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                wr_err_q, wr_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // A write is only taken when the sweep is not running; busy_q mirrors
  // the SWEEP state, so it can serve as the gate directly.
  logic                wr_accept_s;
  assign wr_accept_s = wr_en & ~busy_q;

  // Sweep sequencer next-state: IDLE waits for clr_req, SWEEP walks ptr
  // across every entry and leaves on the edge that clears the last one.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end else begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        // clr_req is deliberately ignored here: no restart, no queuing.
        // ptr wraps to 0 naturally on the final increment.
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Registered status outputs: busy follows the next state so it is high
  // from the request edge up to the edge that clears the last entry.
  always_comb begin
    busy_d   = (state_d == ST_SWEEP);
    wr_err_d = wr_en & busy_q;
  end

  // Storage next value: a sweep write takes priority, otherwise an accepted
  // write. A write accepted in the same cycle as clr_req still lands here;
  // the sweep later overwrites it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (state_q == ST_SWEEP) begin
      mem_d[ptr_q] = RESET_VAL;
    end else if (wr_accept_s) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
  end

  // State, pointer and status flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Register array; reset loads every entry, which also aborts a sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read ports with forwarding: only a write that will actually be accepted
  // is forwarded, so dropped writes during the sweep are never visible.
  assign rd_data_1 = (wr_accept_s && (rd_addr_1 == wr_addr)) ? wr_data : mem_q[rd_addr_1];
  assign rd_data_2 = (wr_accept_s && (rd_addr_2 == wr_addr)) ? wr_data : mem_q[rd_addr_2];
`else
  // Read ports without forwarding: the pre-write value is shown until the
  // accepting edge has passed.
  assign rd_data_1 = mem_q[rd_addr_1];
  assign rd_data_2 = mem_q[rd_addr_2];
`endif

  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rd_addr_1 = '0;
  logic [DW-1:0] rd_data_1;
  logic [AW-1:0] rd_addr_2 = '0;
  logic [DW-1:0] rd_data_2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_req = 1'b0;
  logic          busy;
  logic          wr_err;

  regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
  );

  always #5 if (clk_en) clk = ~clk;

  // Expected response for one clock cycle
  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          bsy;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Reference model: plain array plus "edges of sweep remaining"
  logic [DW-1:0] m_mem [DEPTH];
  int            m_sweep_rem = 0;
  logic          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_sweep_rem = 0;
    m_err = 1'b0;
  endtask

  // Drive one cycle: set inputs, push expected response, advance model past the next edge
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic clr, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    exp_t e;
    logic m_busy;
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd; clr_req = clr;
    rd_addr_1 = ra1; rd_addr_2 = ra2;
    m_busy = (m_sweep_rem > 0);
    e.r1  = (BYP && we && !m_busy && ra1 == wa) ? wd : m_mem[ra1];
    e.r2  = (BYP && we && !m_busy && ra2 == wa) ? wd : m_mem[ra2];
    e.bsy = m_busy;
    e.err = m_err;
    e.cyc = cyc_no;
    cyc_no++;
    exp_q.push_back(e);
    // effect of the coming rising edge
    m_err = we && m_busy;
    if (m_busy) begin
      m_mem[DEPTH - m_sweep_rem] = 8'h00;
      m_sweep_rem--;
    end else begin
      if (we) m_mem[wa] = wd;
      if (clr) m_sweep_rem = DEPTH;
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("rd_data_1 c%0d", e.cyc), {24'h0, rd_data_1}, {24'h0, e.r1});
        chk($sformatf("rd_data_2 c%0d", e.cyc), {24'h0, rd_data_2}, {24'h0, e.r2});
        chk($sformatf("busy c%0d", e.cyc), {31'h0, busy}, {31'h0, e.bsy});
        chk($sformatf("wr_err c%0d", e.cyc), {31'h0, wr_err}, {31'h0, e.err});
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Immediate checks of all entries through the read ports (no clock needed)
  task automatic check_all_reset(input string tag);
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_addr_1 = AW'(2 * i);
      rd_addr_2 = AW'(2 * i + 1);
      #1;
      chk($sformatf("%s rd1 a%0d", tag, 2 * i), {24'h0, rd_data_1}, 32'h0);
      chk($sformatf("%s rd2 a%0d", tag, 2 * i + 1), {24'h0, rd_data_2}, 32'h0);
    end
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " wr_err"}, {31'h0, wr_err}, 32'h0);
  endtask

  initial begin
    int wait_cnt;
    model_reset();

    // Reset pulse with the clock stopped
    #5 reset = 1'b0;
    #1 check_all_reset("por");
    #3 reset = 1'b1;
    #1 check_all_reset("por_rel");

    clk_en = 1'b1;

    // Write/read
    cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd3);
    cycle(1'b1, 3'd7, 8'h5A, 1'b0, 3'd3, 3'd3);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd7);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd7);

    // Same-cycle write/read (bypass or old value)
    cycle(1'b1, 3'd2, 8'h3C, 1'b0, 3'd2, 3'd3);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd2);

    // Fill with 0xFF
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i), 8'hFF, 1'b0, AW'(i), AW'(DEPTH - 1 - i));
    // Start sweep
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 2)      cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd5);       // second clr ignored
      else if (k == 3) cycle(1'b1, 3'd1, 8'h77, 1'b0, 3'd1, 3'd1);       // dropped write
      else if (k == 5) cycle(1'b1, 3'd6, 8'h11, 1'b1, 3'd6, 3'd7);       // clr+wr in sweep
      else             cycle(1'b0, 3'd0, 8'h00, 1'b0, AW'(k), AW'(k + 1));
    end
    // After sweep: every entry reads 0; first write accepted
    for (int i = 0; i < DEPTH / 2; i++) cycle(1'b0, 3'd0, 8'h00, 1'b0, AW'(2 * i), AW'(2 * i + 1));
    cycle(1'b1, 3'd4, 8'h9C, 1'b0, 3'd4, 3'd1);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd1);

    // Write in the same cycle as clr_req completes, then is swept away
    cycle(1'b1, 3'd6, 8'hE1, 1'b1, 3'd6, 3'd6);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd4);
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd4);

    // Reset mid-sweep at sweep cycle 3
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i), 8'hC3, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd7);
    @(posedge clk);
    #2;
    wr_en = 1'b0; clr_req = 1'b0;
    reset = 1'b0;
    model_reset();
    #1 check_all_reset("midsweep");
    reset = 1'b1;
    cycle(1'b1, 3'd5, 8'h42, 1'b0, 3'd5, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd5);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom),
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            AW'($urandom_range(0, DEPTH - 1)),
            AW'($urandom_range(0, DEPTH - 1)));
    end
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1);

    // Drain scoreboard with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: two asynchronous read ports, one synchronous write port, asynchronous reset to a programmable value and a hardware clear sequencer that sweeps every entry back to that value. It replaces the fixed 8x8 register file in the datapath, sitting between decode (read addresses) and writeback (write port). Reset no longer loads from a memory image. All entries start at `RESET_VAL`.

## Interface
Parameters:
- `DATA_W`, 8: width of each register in bits.
- `ADDR_W`, 3: address width; depth is `DEPTH = 2**ADDR_W`, so every address is in range.
- `RESET_VAL`, 0: `DATA_W`-bit value loaded into every entry by reset and by the clear sweep.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_addr_1`  in  `ADDR_W`  read port 1 address.
- `rd_data_1`  out  `DATA_W`  read port 1 data, combinational.
- `rd_addr_2`  in  `ADDR_W`  read port 2 address.
- `rd_data_2`  out  `DATA_W`  read port 2 data, combinational.
- `wr_en`  in  1  write request, sampled at the rising edge.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `clr_req`  in  1  clear-sweep request, sampled at the rising edge.
- `busy`  out  1  high while the sweep runs.
- `wr_err`  out  1  registered one-cycle pulse: a write was dropped because `busy` was high.

## Operation
- Storage: `DEPTH` x `DATA_W` array. Writes happen only on the rising edge of `clk`, never level-sensitive.
- Write accepted when `wr_en` is high and `busy` is low. At the edge, `array[wr_addr] <= wr_data`.
- Reads are combinational: `rd_data_n = array[rd_addr_n]`. Both ports may address the same entry.
- The FSM has two states, IDLE and SWEEP.
  - IDLE, with `clr_req` high at an edge: go to SWEEP with `ptr = 0`. Any write accepted in that same cycle completes, then gets overwritten by the sweep.
  - SWEEP: each edge writes `RESET_VAL` to `array[ptr]` and increments `ptr`. The edge that writes `ptr = DEPTH-1` returns to IDLE, and `ptr` wraps to 0.
  - SWEEP ignores `clr_req`; there is no restart and no queuing.
- `busy` is high exactly while in SWEEP.
- `wr_en` high while `busy` is high: the write is dropped, and `wr_err` is high for the following cycle. `wr_err` is 0 otherwise.
- During SWEEP, reads return current array contents: entries below `ptr` read `RESET_VAL`, the rest read their old values.

## Timing
- Reset values, applied immediately on the falling edge of `reset`, independent of `clk`:
  - every entry = `RESET_VAL`
  - state IDLE, `ptr` = 0, `busy` = 0, `wr_err` = 0
  - `rd_data_n` therefore show `RESET_VAL`.
- Reset asserted mid-sweep aborts the sweep immediately. After release the block is in IDLE.
- Write latency: data is visible on the read ports in the cycle after the accepting edge (without bypass).
- Clear latency: `clr_req` sampled at edge N gives `busy` = 1 from edge N through edge N+`DEPTH`. `busy` falls after edge N+`DEPTH`, and all entries equal `RESET_VAL` at that point.
- The first accepted write after a sweep is at edge N+`DEPTH`+1.
- `clr_req` and `wr_en` arriving together in SWEEP: write dropped, `wr_err` pulses, `clr_req` ignored.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
  - Defined: write-to-read forwarding. In a cycle where a write will be accepted (`wr_en` high, `busy` low) and `rd_addr_n == wr_addr`, `rd_data_n = wr_data` combinationally, in the same cycle. Dropped writes are never forwarded.
  - Undefined: no forwarding. `rd_data_n` shows the pre-write value until after the edge.
- Storage, FSM and error behaviour are identical either way.

## Test plan
- Reset: pulse `reset` low with no `clk` running -> both read ports show `RESET_VAL` (0) for every address; `busy` = 0, `wr_err` = 0.
- Write/read: write 0xA5 to address 3, then 0x5A to address 7, then read 3 on port 1 and 7 on port 2 -> 0xA5 and 0x5A the next cycle. The same address on both ports returns the same value.
- Bypass: write 0x3C to address 2 with `rd_addr_1` = 2 in the same cycle -> `rd_data_1` = 0x3C in that cycle with `REGFILE_BYPASS_EN`, old value without it.
- Sweep: fill all 8 entries with 0xFF, pulse `clr_req` -> `busy` high for exactly 8 cycles; after that every address reads 0x00. A second `clr_req` mid-sweep does not extend `busy`.
- Dropped write: `wr_en` to address 1 with 0x77 during `busy` -> `wr_err` = 1 for one cycle; address 1 reads 0x00 after the sweep.
- Reset mid-sweep: assert `reset` at sweep cycle 3 -> `busy` = 0 immediately, all entries `RESET_VAL`; a write right after release is accepted.
